micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer.sv | 147 ++++++++++++++
 tb/tb_micro_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// ---------------------------------------------------------------------------
// micro_sequencer
//
// Purpose: microprogram sequencer with a writable control store and a
// writable opcode dispatch table. Each micro-instruction carries a 2-bit
// sequencing code and a NEXT address. The sequencer picks the following
// micro-address from one of these sources:
//   00 - sequential (upc+1, wrapping)
//   01 - unconditional jump to NEXT
//   10 - jump to NEXT when cond=1, otherwise sequential
//   11 - jump through dispatch[opcode]
//
// Ports:
//   clk      in   sole clock, rising edge
//   rst      in   asynchronous active-high reset of sequencing state
//   en       in   advance enable (0 = stall, state held)
//   opcode   in   OP_W     dispatch index
//   cond     in   1        branch condition
//   wr_en    in   1        table write strobe
//   wr_sel   in   1        0 = control store, 1 = dispatch table
//   wr_addr  in   WA_W     write address (low bits used)
//   wr_data  in   UIR_W    write data (low ADDR_W bits for dispatch writes)
//   upc      out  ADDR_W   address of the current micro-instruction
//   uir      out  UIR_W    current micro-instruction (registered)
//   ctrl     out  UIR_W-ADDR_W-2  control field of uir
//   valid    out  1        uir holds a fetched instruction
// ---------------------------------------------------------------------------
module micro_sequencer #(
   parameter int ADDR_W = 4,
   parameter int UIR_W  = 15,
   parameter int OP_W   = 4,
   localparam int WA_W  = (ADDR_W > OP_W) ? ADDR_W : OP_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [OP_W-1:0]           opcode,
   input  logic                      cond,
   input  logic                      wr_en,
   input  logic                      wr_sel,
   input  logic [WA_W-1:0]           wr_addr,
   input  logic [UIR_W-1:0]          wr_data,
   output logic [ADDR_W-1:0]         upc,
   output logic [UIR_W-1:0]          uir,
   output logic [UIR_W-ADDR_W-3:0]   ctrl,
   output logic                      valid
);

   localparam int DEPTH   = 2**ADDR_W;
   localparam int N_DISP  = 2**OP_W;

   localparam logic [1:0] SEQ_INC  = 2'b00;
   localparam logic [1:0] SEQ_JMP  = 2'b01;
   localparam logic [1:0] SEQ_COND = 2'b10;

   // FILL: uir not yet loaded since reset; RUN: uir holds store[upc].
   typedef enum logic {ST_FILL = 1'b0, ST_RUN = 1'b1} state_t;

   state_t                state_reg, state_next;
   logic [ADDR_W-1:0]     upc_reg, upc_next;
   logic [UIR_W-1:0]      uir_reg, uir_next;

   logic [UIR_W-1:0]      store_mem [DEPTH];
   logic [ADDR_W-1:0]     disp_mem  [N_DISP];

   logic [1:0]            seq_field;
   logic [ADDR_W-1:0]     next_field;
   logic [ADDR_W-1:0]     upc_inc;
   logic [ADDR_W-1:0]     disp_word;
   logic                  cs_wr, disp_wr;

   // Writes are ignored while reset is held; stall does not block them.
   assign cs_wr   = wr_en && !rst && !wr_sel;
   assign disp_wr = wr_en && !rst &&  wr_sel;

   // -----------------------------------------------------------------------
   // Table storage: plain clocked arrays, untouched by reset.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (cs_wr)
         store_mem[wr_addr[ADDR_W-1:0]] <= wr_data;
      if (disp_wr)
         disp_mem[wr_addr[OP_W-1:0]] <= wr_data[ADDR_W-1:0];
   end

   // -----------------------------------------------------------------------
   // Field decode and next-address selection
   // -----------------------------------------------------------------------
   assign seq_field  = uir_reg[ADDR_W+1:ADDR_W];
   assign next_field = uir_reg[ADDR_W-1:0];
   assign upc_inc    = upc_reg + 1'b1;   // natural wrap at DEPTH-1

   // A dispatch entry being written on this edge is forwarded (write-first).
   always_comb begin
      disp_word = disp_mem[opcode];
      if (disp_wr && (wr_addr[OP_W-1:0] == opcode))
         disp_word = wr_data[ADDR_W-1:0];
   end

   // -----------------------------------------------------------------------
   // Sequencer state register
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_FILL;
         upc_reg   <= '0;
         uir_reg   <= '0;
      end else if (en) begin
         state_reg <= state_next;
         upc_reg   <= upc_next;
         uir_reg   <= uir_next;
      end
   end

   // -----------------------------------------------------------------------
   // Next-state / fetch logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_next = ST_RUN;
      upc_next   = '0;
      uir_next   = '0;

      case (state_reg)
         ST_FILL: upc_next = '0;   // first fetch is store[0], upc stays 0
         ST_RUN: begin
            case (seq_field)
               SEQ_INC:  upc_next = upc_inc;
               SEQ_JMP:  upc_next = next_field;
               SEQ_COND: upc_next = cond ? next_field : upc_inc;
               default:  upc_next = disp_word;
            endcase
         end
         default: upc_next = '0;
      endcase

      // Fetch the addressed word, forwarding a same-edge store write.
      uir_next = store_mem[upc_next];
      if (cs_wr && (wr_addr[ADDR_W-1:0] == upc_next))
         uir_next = wr_data;
   end

   assign upc   = upc_reg;
   assign uir   = uir_reg;
   assign ctrl  = uir_reg[UIR_W-1:ADDR_W+2];
   assign valid = (state_reg == ST_RUN);

endmodule

// File: tb/tb_micro_sequencer.sv
// ---------------------------------------------------------------------------
// tb_micro_sequencer
//
// Directed bench for micro_sequencer with default parameters (ADDR_W=4,
// UIR_W=15, OP_W=4). Loads a small microprogram, walks it through fill,
// sequential, dispatch (with stall), jump, wrap, conditional branch,
// asynchronous reset and write-first fetch. Inputs change on the falling
// edge; outputs are sampled on the falling edge after each rising edge.
// ---------------------------------------------------------------------------
module tb_micro_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  opcode;
   logic        cond;
   logic        wr_en;
   logic        wr_sel;
   logic [3:0]  wr_addr;
   logic [14:0] wr_data;
   logic [3:0]  upc;
   logic [14:0] uir;
   logic [8:0]  ctrl;
   logic        valid;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   micro_sequencer #(.ADDR_W(4), .UIR_W(15), .OP_W(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .opcode  (opcode),
      .cond    (cond),
      .wr_en   (wr_en),
      .wr_sel  (wr_sel),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .upc     (upc),
      .uir     (uir),
      .ctrl    (ctrl),
      .valid   (valid)
   );

   // Micro-instruction word: {ctrl[8:0], seq[1:0], next[3:0]}
   function automatic logic [14:0] mk(input logic [8:0] c, input logic [1:0] s,
                                      input logic [3:0] n);
      return {c, s, n};
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic write_cs(input logic [3:0] a, input logic [14:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic write_disp(input logic [3:0] a, input logic [3:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = a; wr_data = {11'd0, d};
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // One enabled rising edge; returns at the following falling edge.
   task automatic step;
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
   endtask

   task automatic expect_state(input string tag, input logic [3:0] e_upc,
                               input logic [14:0] e_uir);
      check({tag, ".upc"},   32'(upc),   32'(e_upc));
      check({tag, ".uir"},   32'(uir),   32'(e_uir));
      check({tag, ".ctrl"},  32'(ctrl),  32'(e_uir[14:6]));
      check({tag, ".valid"}, 32'(valid), 32'd1);
      $display("step %-10s upc=%0d uir=0x%04h valid=%0b", tag, upc, uir, valid);
   endtask

   logic [14:0] s0, s1, s2, s3, s5, s6, s7, s9, s12, s15, x8;

   initial begin
      s0  = mk(9'h001, 2'b00, 4'd0);
      s1  = mk(9'h002, 2'b00, 4'd0);
      s2  = mk(9'h003, 2'b11, 4'd0);
      s3  = mk(9'h004, 2'b01, 4'd9);
      s5  = mk(9'h005, 2'b10, 4'd12);
      s6  = mk(9'h006, 2'b01, 4'd1);
      s7  = mk(9'h007, 2'b01, 4'd3);
      s9  = mk(9'h009, 2'b01, 4'd15);
      s12 = mk(9'h00C, 2'b01, 4'd5);
      s15 = mk(9'h00F, 2'b00, 4'd0);
      x8  = mk(9'h155, 2'b01, 4'd0);

      rst = 1'b1; en = 1'b0; opcode = 4'd4; cond = 1'b0;
      wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;

      #1;
      check("rst.upc",   32'(upc),   32'd0);
      check("rst.uir",   32'(uir),   32'd0);
      check("rst.ctrl",  32'(ctrl),  32'd0);
      check("rst.valid", 32'(valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Load microprogram and dispatch table while stalled.
      write_cs(4'd0, s0);   write_cs(4'd1, s1);   write_cs(4'd2, s2);
      write_cs(4'd3, s3);   write_cs(4'd5, s5);   write_cs(4'd6, s6);
      write_cs(4'd7, s7);   write_cs(4'd9, s9);   write_cs(4'd12, s12);
      write_cs(4'd15, s15);
      write_disp(4'd4, 4'd7);
      write_disp(4'd6, 4'd8);
      check("stall.valid", 32'(valid), 32'd0);

      // Fill then sequential.
      step; expect_state("fill0", 4'd0, s0);
      step; expect_state("seq1",  4'd1, s1);
      step; expect_state("seq2",  4'd2, s2);

      // Stall at a dispatch word: opcode wiggles and a dispatch write occur.
      opcode = 4'd9;
      @(negedge clk);
      opcode = 4'd5;
      write_disp(4'd5, 4'd5);
      expect_state("hold", 4'd2, s2);
      opcode = 4'd4;

      step; expect_state("disp7",  4'd7,  s7);
      step; expect_state("jmp3",   4'd3,  s3);
      step; expect_state("jmp9",   4'd9,  s9);
      step; expect_state("jmp15",  4'd15, s15);
      step; expect_state("wrap0",  4'd0,  s0);
      step; expect_state("seq1b",  4'd1,  s1);
      step; expect_state("seq2b",  4'd2,  s2);
      opcode = 4'd5;
      step; expect_state("disp5",  4'd5,  s5);
      cond = 1'b1;
      step; expect_state("br12",   4'd12, s12);
      cond = 1'b0;
      step; expect_state("jmp5",   4'd5,  s5);
      step; expect_state("nobr6",  4'd6,  s6);

      // Asynchronous reset between edges, plus a write attempted under reset.
      #2 rst = 1'b1;
      #1;
      check("arst.upc",   32'(upc),   32'd0);
      check("arst.uir",   32'(uir),   32'd0);
      check("arst.ctrl",  32'(ctrl),  32'd0);
      check("arst.valid", 32'(valid), 32'd0);
      $display("step %-10s upc=%0d uir=0x%04h valid=%0b", "arst", upc, uir, valid);
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 15'h7FFF;
      en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; en = 1'b0;
      check("arst.hold_upc", 32'(upc), 32'd0);
      rst = 1'b0;

      // Refetch from 0; store contents survive reset.
      step; expect_state("refill0", 4'd0, s0);
      step; expect_state("reseq1",  4'd1, s1);
      opcode = 4'd6;
      step; expect_state("reseq2",  4'd2, s2);

      // Write store[8] on the same edge that fetches address 8.
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd8; wr_data = x8;
      step;
      wr_en = 1'b0;
      expect_state("wfirst8", 4'd8, x8);
      step; expect_state("after8", 4'd0, s0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
